// File: rtl/dot_pkg.sv
// Shared definitions for the dot-product engine and its downstream writer.
package dot_pkg;

    localparam int unsigned DEF_DATA_WIDTH   = 8;
    localparam int unsigned DEF_VECTOR_WIDTH = 4;
    localparam int unsigned DEF_ADDR_WIDTH   = 6;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StFetch   = 3'd1,
        StDrain   = 3'd2,
        StWaitWr  = 3'd3,
        StOutput  = 3'd4,
        StDone    = 3'd5
    } state_t;

    // Accumulator width that can hold vw full-width products without overflow.
    function automatic int unsigned result_width(input int unsigned dw, input int unsigned vw);
        return 2 * dw + $clog2(vw);
    endfunction

endpackage

// File: rtl/dp_mac.sv
// Registered unsigned multiply-accumulate with synchronous clear and enable.
module dp_mac #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned RESULT_WIDTH = 18
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_clear,
    input  logic                    i_en,
    input  logic [DATA_WIDTH-1:0]   i_a,
    input  logic [DATA_WIDTH-1:0]   i_b,
    output logic [RESULT_WIDTH-1:0] o_acc
);

    localparam int unsigned PROD_WIDTH = 2 * DATA_WIDTH;

    logic [PROD_WIDTH-1:0]   w_prod;
    logic [RESULT_WIDTH-1:0] r_acc;

    assign w_prod = PROD_WIDTH'(i_a) * PROD_WIDTH'(i_b);

    // Clear wins over enable so a new job never inherits a stale sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc + RESULT_WIDTH'(w_prod);
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/dot_product_engine.sv
// Fetches VECTOR_WIDTH operand pairs, accumulates their products and hands
// the sum to the downstream writer with a valid/done pulse pair.
module dot_product_engine
    import dot_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int unsigned VECTOR_WIDTH = DEF_VECTOR_WIDTH,
    parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int unsigned RESULT_WIDTH = result_width(DATA_WIDTH, VECTOR_WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   base_address,
    output logic                    read_en,
    output logic [ADDR_WIDTH-1:0]   read_address,
    input  logic [DATA_WIDTH-1:0]   data_out_a,
    input  logic [DATA_WIDTH-1:0]   data_out_b,
    input  logic                    writer_busy,
    output logic [RESULT_WIDTH-1:0] dot_product_result,
    output logic                    result_valid,
    output logic                    processing_done,
    output logic                    engine_busy,
    output logic [2:0]              result_count
);

    localparam int unsigned IDX_WIDTH = $clog2(VECTOR_WIDTH);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(VECTOR_WIDTH - 1);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [ADDR_WIDTH-1:0]   r_base;
    logic [IDX_WIDTH-1:0]    r_idx;
    logic                    r_rd_valid;
    logic [2:0]              r_count;
    logic                    w_accept;
    logic                    w_fetch;
    logic [ADDR_WIDTH-1:0]   w_addr;

    assign w_accept = (r_state == StIdle) && start;
    assign w_fetch  = (r_state == StFetch);
    // Address wraps naturally at the ADDR_WIDTH boundary.
    assign w_addr   = r_base + ADDR_WIDTH'(r_idx);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Job setup, element index and the read-data valid delay line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base     <= '0;
            r_idx      <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_fetch;
            if (w_accept) begin
                r_base <= base_address;
                r_idx  <= '0;
            end else if (w_fetch) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    // Count of issued results, wraps modulo 8.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (r_state == StOutput) begin
            r_count <= r_count + 3'd1;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:   if (start) w_state_next = StFetch;
            StFetch:  if (r_idx == LAST_IDX) w_state_next = StDrain;
            StDrain:  w_state_next = writer_busy ? StWaitWr : StOutput;
            StWaitWr: if (!writer_busy) w_state_next = StOutput;
            StOutput: w_state_next = StDone;
            StDone:   w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    // Accumulator stays untouched after the drain, so it doubles as the held result.
    dp_mac #(
        .DATA_WIDTH   (DATA_WIDTH),
        .RESULT_WIDTH (RESULT_WIDTH)
    ) u_mac (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_accept),
        .i_en    (r_rd_valid),
        .i_a     (data_out_a),
        .i_b     (data_out_b),
        .o_acc   (dot_product_result)
    );

    assign read_en         = w_fetch;
    assign read_address    = w_fetch ? w_addr : '0;
    assign result_valid    = (r_state == StOutput);
    assign processing_done = (r_state == StDone);
    assign engine_busy     = (r_state != StIdle);
    assign result_count    = r_count;

endmodule
